// File: rtl/cmd_pkg.sv
// ---------------------------------------------------------------------------
// cmd_pkg
// Shared definitions for the command-configuration stage: host opcodes,
// response bytes, command FSM state encoding and watchdog widths.
// No ports (package).
// ---------------------------------------------------------------------------
package cmd_pkg;

    // Host opcodes
    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] SET_CAL   = 8'h06;
    localparam logic [7:0] SET_EMGL  = 8'h07;
    localparam logic [7:0] SET_MOFF  = 8'h08;

    // Response bytes returned to the host
    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_NAK = 8'hEE;

    // Communication-loss watchdog widths (fast variant shortens simulation)
    localparam int WD_W_FAST = 32'd9;
    localparam int WD_W_FULL = 32'd26;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        CAL_WAIT = 2'b01,
        RESP     = 2'b10
    } state_t;

endpackage

// File: rtl/cmd_watchdog.sv
// ---------------------------------------------------------------------------
// cmd_watchdog
// Saturating up-counter used as the communication-loss watchdog.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset (count -> 0)
//   clr     in  synchronous clear, dominates enable
//   en      in  count enable
//   timeout out high while the count is saturated at all-ones
// ---------------------------------------------------------------------------
module cmd_watchdog #(
    parameter int W = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment until saturated and hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = CNT_ZERO;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (cnt_q == CNT_MAX);

endmodule

// File: rtl/cmd_cfg.sv
// ---------------------------------------------------------------------------
// cmd_cfg
// Command-configuration stage between the UART command wrapper and the
// flight controller. Decodes host packets (opcode + 16-bit data), holds the
// pitch/roll/yaw/thrust setpoints, sequences inertial calibration, drives
// motors_off and answers every packet with an ACK/NAK byte. A watchdog
// zeroes the setpoints if the host goes silent while the motors are live.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cmd_rdy, cmd, data   incoming packet, held until clr_cmd_rdy
//   clr_cmd_rdy          combinational consume pulse (same cycle as accept)
//   send_resp, resp      one-cycle launch of the response byte
//   cal_done             calibration complete pulse from the inertial unit
//   strt_cal             one-cycle calibration start pulse
//   inertial_cal         high throughout calibration
//   d_ptch/d_roll/d_yaw  signed setpoints
//   thrst                unsigned 9-bit thrust setpoint
//   motors_off           forces the ESC drivers to idle
// ---------------------------------------------------------------------------
module cmd_cfg
    import cmd_pkg::*;
#(
    parameter bit         FAST_SIM = 1'b0,
    parameter logic [7:0] ACK      = RESP_ACK,
    parameter logic [7:0] NAK      = RESP_NAK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_rdy,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    output logic [7:0]  resp,
    input  logic        cal_done,
    output logic        strt_cal,
    output logic        inertial_cal,
    output logic [15:0] d_ptch,
    output logic [15:0] d_roll,
    output logic [15:0] d_yaw,
    output logic [8:0]  thrst,
    output logic        motors_off
);

    localparam int WD_W = FAST_SIM ? WD_W_FAST : WD_W_FULL;

    state_t      state_q,        state_d;
    logic        send_resp_q,    send_resp_d;
    logic [7:0]  resp_q,         resp_d;
    logic        strt_cal_q,     strt_cal_d;
    logic        inertial_cal_q, inertial_cal_d;
    logic [15:0] d_ptch_q,       d_ptch_d;
    logic [15:0] d_roll_q,       d_roll_d;
    logic [15:0] d_yaw_q,        d_yaw_d;
    logic [8:0]  thrst_q,        thrst_d;
    logic        motors_off_q,   motors_off_d;

    logic        accept_s;
    logic        wd_clr_s;
    logic        wd_en_s;
    logic        wd_timeout_s;

    // A packet is taken only from IDLE; in CAL_WAIT it simply stays pending
    assign accept_s = (state_q == IDLE) && cmd_rdy;

    // Watchdog is held at zero while disarmed (motors off) or calibrating
    assign wd_clr_s = accept_s || motors_off_q || (state_q == CAL_WAIT);
    assign wd_en_s  = !motors_off_q;

    cmd_watchdog #(
        .W (WD_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr_s),
        .en      (wd_en_s),
        .timeout (wd_timeout_s)
    );

    // Next-state, opcode decode and output computation
    always_comb begin
        state_d        = state_q;
        send_resp_d    = 1'b0;
        resp_d         = resp_q;
        strt_cal_d     = 1'b0;
        inertial_cal_d = inertial_cal_q;
        d_ptch_d       = d_ptch_q;
        d_roll_d       = d_roll_q;
        d_yaw_d        = d_yaw_q;
        thrst_d        = thrst_q;
        motors_off_d   = motors_off_q;

        // Comm loss: land softly, but a packet arriving now takes priority
        if (wd_timeout_s && !accept_s) begin
            d_ptch_d = 16'h0000;
            d_roll_d = 16'h0000;
            d_yaw_d  = 16'h0000;
            thrst_d  = 9'h000;
        end else begin
            d_ptch_d = d_ptch_q;
        end

        case (state_q)
            IDLE: begin
                if (cmd_rdy) begin
                    state_d     = RESP;
                    send_resp_d = 1'b1;
                    resp_d      = ACK;
                    case (cmd)
                        SET_PTCH:  d_ptch_d = data;
                        SET_ROLL:  d_roll_d = data;
                        SET_YAW:   d_yaw_d  = data;
                        SET_THRST: thrst_d  = data[8:0];
                        SET_EMGL: begin
                            d_ptch_d = 16'h0000;
                            d_roll_d = 16'h0000;
                            d_yaw_d  = 16'h0000;
                            thrst_d  = 9'h000;
                        end
                        SET_MOFF: begin
                            motors_off_d = 1'b1;
                            thrst_d      = 9'h000;
                        end
                        // Calibration answers only once cal_done arrives
                        SET_CAL: begin
                            state_d        = CAL_WAIT;
                            send_resp_d    = 1'b0;
                            resp_d         = resp_q;
                            strt_cal_d     = 1'b1;
                            inertial_cal_d = 1'b1;
                            motors_off_d   = 1'b0;
                        end
                        default: resp_d = NAK;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            CAL_WAIT: begin
                if (cal_done) begin
                    state_d        = RESP;
                    send_resp_d    = 1'b1;
                    resp_d         = ACK;
                    inertial_cal_d = 1'b0;
                end else begin
                    state_d = CAL_WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            send_resp_q    <= 1'b0;
            resp_q         <= ACK;
            strt_cal_q     <= 1'b0;
            inertial_cal_q <= 1'b0;
            d_ptch_q       <= 16'h0000;
            d_roll_q       <= 16'h0000;
            d_yaw_q        <= 16'h0000;
            thrst_q        <= 9'h000;
            motors_off_q   <= 1'b1;
        end else begin
            state_q        <= state_d;
            send_resp_q    <= send_resp_d;
            resp_q         <= resp_d;
            strt_cal_q     <= strt_cal_d;
            inertial_cal_q <= inertial_cal_d;
            d_ptch_q       <= d_ptch_d;
            d_roll_q       <= d_roll_d;
            d_yaw_q        <= d_yaw_d;
            thrst_q        <= thrst_d;
            motors_off_q   <= motors_off_d;
        end
    end

    assign clr_cmd_rdy  = accept_s;
    assign send_resp    = send_resp_q;
    assign resp         = resp_q;
    assign strt_cal     = strt_cal_q;
    assign inertial_cal = inertial_cal_q;
    assign d_ptch       = d_ptch_q;
    assign d_roll       = d_roll_q;
    assign d_yaw        = d_yaw_q;
    assign thrst        = thrst_q;
    assign motors_off   = motors_off_q;

endmodule

// File: tb/tb_cmd_cfg.sv
// ---------------------------------------------------------------------------
// tb_cmd_cfg
// Directed self-checking bench for cmd_cfg (fast watchdog variant).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_cmd_cfg;

    logic        clk;
    logic        rst;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        cal_done;
    logic        strt_cal;
    logic        inertial_cal;
    logic [15:0] d_ptch;
    logic [15:0] d_roll;
    logic [15:0] d_yaw;
    logic [8:0]  thrst;
    logic        motors_off;

    int checks = 0;
    int errors = 0;

    cmd_cfg #(
        .FAST_SIM (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_rdy      (cmd_rdy),
        .cmd          (cmd),
        .data         (data),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .send_resp    (send_resp),
        .resp         (resp),
        .cal_done     (cal_done),
        .strt_cal     (strt_cal),
        .inertial_cal (inertial_cal),
        .d_ptch       (d_ptch),
        .d_roll       (d_roll),
        .d_yaw        (d_yaw),
        .thrst        (thrst),
        .motors_off   (motors_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a packet and wait (bounded) for it to be consumed; returns in
    // the cycle after acceptance, 1 ns past the accept edge.
    task automatic send_pkt(input logic [7:0] op, input logic [15:0] d);
        bit seen = 1'b0;
        cmd = op; data = d; cmd_rdy = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (clr_cmd_rdy === 1'b1) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        cmd_rdy = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("FAIL accept_%h: clr_cmd_rdy got 0 expected 1 within 20 cycles", op); end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_rdy = 1'b0; cal_done = 1'b0; cmd = 8'h00; data = 16'h0000;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (motors_off !== 1'b1) begin errors++; $display("FAIL rst_motors_off: got %b expected 1", motors_off); end
        checks++; if (resp !== 8'hA5) begin errors++; $display("FAIL rst_resp: got %h expected a5", resp); end
        checks++; if ({d_ptch, d_roll, d_yaw} !== 48'h0) begin errors++; $display("FAIL rst_setpoints: got %h expected 0", {d_ptch, d_roll, d_yaw}); end
        checks++; if (thrst !== 9'h000) begin errors++; $display("FAIL rst_thrst: got %h expected 0", thrst); end
        checks++; if ({send_resp, strt_cal, inertial_cal, clr_cmd_rdy} !== 4'b0000) begin errors++; $display("FAIL rst_pulses: got %b expected 0000", {send_resp, strt_cal, inertial_cal, clr_cmd_rdy}); end
        @(posedge clk); #1;
    endtask

    task automatic test_thrust();
        send_pkt(8'h05, 16'h00FF);
        @(negedge clk);
        checks++; if (thrst !== 9'h0FF) begin errors++; $display("FAIL thrst_load: got %h expected 0ff", thrst); end
        checks++; if (send_resp !== 1'b1 || resp !== 8'hA5) begin errors++; $display("FAIL thrst_ack: got send_resp=%b resp=%h expected 1/a5", send_resp, resp); end
        checks++; if (motors_off !== 1'b1) begin errors++; $display("FAIL thrst_moff: got %b expected 1", motors_off); end
        @(posedge clk); #1; @(negedge clk);
        checks++; if (send_resp !== 1'b0) begin errors++; $display("FAIL thrst_resp_len: got %b expected 0", send_resp); end
        @(posedge clk); #1;
        send_pkt(8'h05, 16'hFE37);
        @(negedge clk);
        checks++; if (thrst !== 9'h037) begin errors++; $display("FAIL thrst_trunc: got %h expected 037", thrst); end
        @(posedge clk); #1;
    endtask

    task automatic test_cal();
        int hi = 0;
        send_pkt(8'h06, 16'h0000);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (inertial_cal === 1'b1) hi++;
            if (i == 0) begin
                checks++; if (strt_cal !== 1'b1) begin errors++; $display("FAIL cal_strt: got %b expected 1", strt_cal); end
                checks++; if (motors_off !== 1'b0 || send_resp !== 1'b0) begin errors++; $display("FAIL cal_enter: got moff=%b send_resp=%b expected 0/0", motors_off, send_resp); end
            end
            if (i == 1) begin
                checks++; if (strt_cal !== 1'b0) begin errors++; $display("FAIL cal_strt_len: got %b expected 0", strt_cal); end
            end
            @(posedge clk); #1;
        end
        cal_done = 1'b1;
        @(negedge clk);
        checks++; if (send_resp !== 1'b0) begin errors++; $display("FAIL cal_early_resp: got %b expected 0", send_resp); end
        @(posedge clk); #1;
        cal_done = 1'b0;
        @(negedge clk);
        checks++; if (send_resp !== 1'b1 || resp !== 8'hA5) begin errors++; $display("FAIL cal_ack: got send_resp=%b resp=%h expected 1/a5", send_resp, resp); end
        checks++; if (inertial_cal !== 1'b0 || motors_off !== 1'b0) begin errors++; $display("FAIL cal_exit: got ical=%b moff=%b expected 0/0", inertial_cal, motors_off); end
        checks++; if (hi != 40) begin errors++; $display("FAIL cal_len: got %0d expected 40", hi); end
        @(posedge clk); #1;
    endtask

    task automatic test_setpoints();
        send_pkt(8'h02, 16'h0100);
        @(negedge clk);
        checks++; if (d_ptch !== 16'h0100 || send_resp !== 1'b1 || resp !== 8'hA5) begin errors++; $display("FAIL ptch: got %h/%b/%h expected 0100/1/a5", d_ptch, send_resp, resp); end
        @(posedge clk); #1;
        send_pkt(8'h03, 16'hFF80);
        @(negedge clk);
        checks++; if ($signed(d_roll) != -128 || send_resp !== 1'b1 || resp !== 8'hA5) begin errors++; $display("FAIL roll: got %h/%b/%h expected ff80/1/a5", d_roll, send_resp, resp); end
        @(posedge clk); #1;
        send_pkt(8'h04, 16'h0080);
        @(negedge clk);
        checks++; if (d_yaw !== 16'h0080 || send_resp !== 1'b1 || resp !== 8'hA5) begin errors++; $display("FAIL yaw: got %h/%b/%h expected 0080/1/a5", d_yaw, send_resp, resp); end
        checks++; if (d_ptch !== 16'h0100 || d_roll !== 16'hFF80) begin errors++; $display("FAIL sp_hold: got %h %h expected 0100 ff80", d_ptch, d_roll); end
        @(posedge clk); #1;
    endtask

    task automatic test_emgl_moff();
        send_pkt(8'h07, 16'h1234);
        @(negedge clk);
        checks++; if ({d_ptch, d_roll, d_yaw} !== 48'h0 || thrst !== 9'h000) begin errors++; $display("FAIL emgl: got %h %h %h %h expected 0", d_ptch, d_roll, d_yaw, thrst); end
        checks++; if (send_resp !== 1'b1 || resp !== 8'hA5 || motors_off !== 1'b0) begin errors++; $display("FAIL emgl_ack: got %b/%h/moff=%b expected 1/a5/0", send_resp, resp, motors_off); end
        @(posedge clk); #1;
        send_pkt(8'h05, 16'h0055);
        @(negedge clk);
        @(posedge clk); #1;
        send_pkt(8'h08, 16'h0000);
        @(negedge clk);
        checks++; if (motors_off !== 1'b1 || thrst !== 9'h000) begin errors++; $display("FAIL moff: got moff=%b thrst=%h expected 1/000", motors_off, thrst); end
        checks++; if (send_resp !== 1'b1 || resp !== 8'hA5) begin errors++; $display("FAIL moff_ack: got %b/%h expected 1/a5", send_resp, resp); end
        @(posedge clk); #1;
    endtask

    task automatic test_nak();
        send_pkt(8'h02, 16'h0042);
        @(negedge clk);
        @(posedge clk); #1;
        send_pkt(8'h1F, 16'hFFFF);
        @(negedge clk);
        checks++; if (send_resp !== 1'b1 || resp !== 8'hEE) begin errors++; $display("FAIL nak: got %b/%h expected 1/ee", send_resp, resp); end
        checks++; if (d_ptch !== 16'h0042 || thrst !== 9'h000 || d_yaw !== 16'h0000) begin errors++; $display("FAIL nak_hold: got %h %h %h expected 0042 000 0000", d_ptch, thrst, d_yaw); end
        @(posedge clk); #1; @(negedge clk);
        checks++; if (send_resp !== 1'b0) begin errors++; $display("FAIL nak_len: got %b expected 0", send_resp); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        cmd = 8'h03; data = 16'h0011; cmd_rdy = 1'b1;
        @(negedge clk);
        checks++; if (clr_cmd_rdy !== 1'b1) begin errors++; $display("FAIL b2b_clr1: got %b expected 1", clr_cmd_rdy); end
        @(posedge clk); #1;
        cmd = 8'h04; data = 16'h0022;
        @(negedge clk);
        checks++; if (clr_cmd_rdy !== 1'b0 || send_resp !== 1'b1 || d_roll !== 16'h0011 || resp !== 8'hA5) begin errors++; $display("FAIL b2b_resp1: got clr=%b sr=%b roll=%h resp=%h expected 0/1/0011/a5", clr_cmd_rdy, send_resp, d_roll, resp); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (clr_cmd_rdy !== 1'b1) begin errors++; $display("FAIL b2b_clr2: got %b expected 1", clr_cmd_rdy); end
        @(posedge clk); #1;
        cmd_rdy = 1'b0;
        @(negedge clk);
        checks++; if (d_yaw !== 16'h0022 || send_resp !== 1'b1) begin errors++; $display("FAIL b2b_resp2: got yaw=%h sr=%b expected 0022/1", d_yaw, send_resp); end
        @(posedge clk); #1;
    endtask

    task automatic test_cal_pending();
        send_pkt(8'h06, 16'h0000);
        repeat (5) @(posedge clk);
        #1;
        cmd = 8'h02; data = 16'h1234; cmd_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (clr_cmd_rdy !== 1'b0) begin errors++; $display("FAIL pend_hold%0d: got %b expected 0", i, clr_cmd_rdy); end
            @(posedge clk); #1;
        end
        cal_done = 1'b1;
        @(posedge clk); #1;
        cal_done = 1'b0;
        @(negedge clk);
        checks++; if (send_resp !== 1'b1 || resp !== 8'hA5 || clr_cmd_rdy !== 1'b0) begin errors++; $display("FAIL pend_ack: got sr=%b resp=%h clr=%b expected 1/a5/0", send_resp, resp, clr_cmd_rdy); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (clr_cmd_rdy !== 1'b1) begin errors++; $display("FAIL pend_accept: got %b expected 1", clr_cmd_rdy); end
        @(posedge clk); #1;
        cmd_rdy = 1'b0;
        @(negedge clk);
        checks++; if (d_ptch !== 16'h1234 || send_resp !== 1'b1) begin errors++; $display("FAIL pend_apply: got %h/%b expected 1234/1", d_ptch, send_resp); end
        @(posedge clk); #1;
    endtask

    task automatic test_watchdog();
        send_pkt(8'h05, 16'h0100);
        repeat (500) @(posedge clk);
        #1; @(negedge clk);
        checks++; if (thrst !== 9'h100 || d_ptch !== 16'h1234) begin errors++; $display("FAIL wd_early: got thrst=%h ptch=%h expected 100/1234", thrst, d_ptch); end
        repeat (15) @(posedge clk);
        #1; @(negedge clk);
        checks++; if (thrst !== 9'h000 || {d_ptch, d_roll, d_yaw} !== 48'h0) begin errors++; $display("FAIL wd_zero: got %h %h %h %h expected 0", d_ptch, d_roll, d_yaw, thrst); end
        checks++; if (motors_off !== 1'b0) begin errors++; $display("FAIL wd_moff: got %b expected 0", motors_off); end
        @(posedge clk); #1;
        send_pkt(8'h05, 16'h0040);
        @(negedge clk);
        checks++; if (thrst !== 9'h040 || send_resp !== 1'b1) begin errors++; $display("FAIL wd_restore: got %h/%b expected 040/1", thrst, send_resp); end
        repeat (20) @(posedge clk);
        #1; @(negedge clk);
        checks++; if (thrst !== 9'h040) begin errors++; $display("FAIL wd_cleared: got %h expected 040", thrst); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_cal();
        send_pkt(8'h06, 16'h0000);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (motors_off !== 1'b1 || inertial_cal !== 1'b0 || thrst !== 9'h000) begin errors++; $display("FAIL rstcal: got moff=%b ical=%b thrst=%h expected 1/0/000", motors_off, inertial_cal, thrst); end
        @(posedge clk); #1;
        cal_done = 1'b1;
        @(posedge clk); #1;
        cal_done = 1'b0;
        @(negedge clk);
        checks++; if (send_resp !== 1'b0 || inertial_cal !== 1'b0) begin errors++; $display("FAIL stray_cal_done: got sr=%b ical=%b expected 0/0", send_resp, inertial_cal); end
        @(posedge clk); #1;
        send_pkt(8'h04, 16'h0007);
        @(negedge clk);
        checks++; if (d_yaw !== 16'h0007 || send_resp !== 1'b1) begin errors++; $display("FAIL rstcal_idle: got %h/%b expected 0007/1", d_yaw, send_resp); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_thrust();
        test_cal();
        test_setpoints();
        test_emgl_moff();
        test_nak();
        test_back_to_back();
        test_cal_pending();
        test_watchdog();
        test_reset_mid_cal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running, required completion");
        $fatal(1, "time limit");
    end

endmodule
